// File: rtl/thee_pulse_period_meter.sv
// Period / duty-cycle meter: counts reference ticks over MEAS_WINDOW periods of sig_in.
// Latency: sig_in edge reaches the FSM SYNC_STAGES+1 clk later; results registered one clk after the closing edge.
// No backpressure: start is a request, ignored while busy; results hold until the next meas_valid.
// Optional build macro THEE_PERIOD_METER_CONT_EN: back-to-back windows without returning to IDLE.
module thee_pulse_period_meter #(
  parameter int CNT_W       = 24,
  parameter int MEAS_WINDOW = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             start,
  output logic             busy,
  output logic             meas_valid,
  output logic [CNT_W-1:0] period_total,
  output logic [CNT_W-1:0] high_total,
  output logic             overflow
);

  // Edge counter only needs to reach MEAS_WINDOW-1; the last rise closes the window.
  localparam int EW = (MEAS_WINDOW > 1) ? $clog2(MEAS_WINDOW) : 1;
  localparam logic [EW-1:0]    LAST_EDGE = EW'(MEAS_WINDOW - 1);
  localparam logic [CNT_W-1:0] ACC_MAX   = '1;
  localparam logic [CNT_W-1:0] ACC_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sig_d;
  logic                   sig_s;
  logic                   rise;
  logic [CNT_W-1:0]       high_inc;
  logic [CNT_W-1:0]       period_acc;
  logic [CNT_W-1:0]       high_acc;
  logic [EW-1:0]          edge_cnt;

  assign sig_s    = sync_q[SYNC_STAGES-1];
  assign rise     = sig_s & ~sig_d;
  assign high_inc = {{(CNT_W-1){1'b0}}, sig_s};

  // Synchronizer chain plus one delay flop for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      sig_d  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      sig_d  <= sig_s;
    end
  end

  // Measurement FSM with accumulators and registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      busy         <= 1'b0;
      meas_valid   <= 1'b0;
      period_total <= '0;
      high_total   <= '0;
      overflow     <= 1'b0;
      period_acc   <= '0;
      high_acc     <= '0;
      edge_cnt     <= '0;
    end else begin
      meas_valid <= 1'b0;
      case (state)
        IDLE: begin
          // A rise in this same cycle is deliberately not used: ARM waits for the next one.
          if (start) begin
            period_acc <= '0;
            high_acc   <= '0;
            edge_cnt   <= '0;
            busy       <= 1'b1;
            state      <= ARM;
          end
        end
        ARM: begin
          if (rise) begin
            // Opening rise cycle is inside the window, so it is counted here.
            period_acc <= ACC_ONE;
            high_acc   <= high_inc;
            edge_cnt   <= '0;
            state      <= MEASURE;
          end else if (period_acc == ACC_MAX) begin
            period_total <= '1;
            high_total   <= '1;
            overflow     <= 1'b1;
            meas_valid   <= 1'b1;
            busy         <= 1'b0;
            state        <= IDLE;
          end else begin
            period_acc <= period_acc + 1'b1;
          end
        end
        MEASURE: begin
          if (rise && (edge_cnt == LAST_EDGE)) begin
            // Closing rise cycle is excluded: latch the sums before adding it.
            period_total <= period_acc;
            high_total   <= high_acc;
            overflow     <= 1'b0;
            meas_valid   <= 1'b1;
`ifdef THEE_PERIOD_METER_CONT_EN
            // Closing edge doubles as the next opening edge.
            period_acc   <= ACC_ONE;
            high_acc     <= high_inc;
            edge_cnt     <= '0;
`else
            busy         <= 1'b0;
            state        <= IDLE;
`endif
          end else if (period_acc == ACC_MAX) begin
            // high_acc never exceeds period_acc, so only period_acc needs a guard.
            period_total <= '1;
            high_total   <= '1;
            overflow     <= 1'b1;
            meas_valid   <= 1'b1;
            busy         <= 1'b0;
            state        <= IDLE;
          end else begin
            period_acc <= period_acc + 1'b1;
            high_acc   <= high_acc + high_inc;
            if (rise) edge_cnt <= edge_cnt + 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_thee_pulse_period_meter.sv
`timescale 1ns/1ps
module tb_thee_pulse_period_meter;

  logic        clk;
  logic        rst_n;
  logic        sig_a, start_a, busy_a, valid_a, ovf_a;
  logic [23:0] per_tot_a, hi_tot_a;
  logic        sig_b, start_b, busy_b, valid_b, ovf_b;
  logic [7:0]  per_tot_b, hi_tot_b;

  int n_tests = 0;
  int n_fail  = 0;
  int nv_a = 0;
  int nv_b = 0;
  int per_a = 20, hi_a = 14, ph_a = 0;
  int per_b = 30, hi_b = 10, ph_b = 0;
  bit en_a = 0, en_b = 0;
  int cyc;
  int nv0;

  thee_pulse_period_meter #(.CNT_W(24), .MEAS_WINDOW(10), .SYNC_STAGES(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_a), .start(start_a), .busy(busy_a),
    .meas_valid(valid_a), .period_total(per_tot_a), .high_total(hi_tot_a), .overflow(ovf_a)
  );

  thee_pulse_period_meter #(.CNT_W(8), .MEAS_WINDOW(10), .SYNC_STAGES(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_b), .start(start_b), .busy(busy_b),
    .meas_valid(valid_b), .period_total(per_tot_b), .high_total(hi_tot_b), .overflow(ovf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Oscillator models: exact period/high time in clk ticks, updated 1ns after posedge.
  always @(posedge clk) begin
    #1;
    if (!en_a) begin ph_a = per_a - 1; sig_a = 1'b0; end
    else begin ph_a = (ph_a + 1) % per_a; sig_a = (ph_a < hi_a); end
    if (!en_b) begin ph_b = per_b - 1; sig_b = 1'b0; end
    else begin ph_b = (ph_b + 1) % per_b; sig_b = (ph_b < hi_b); end
  end

  // Count result pulses for "exactly one result" checks.
  always @(posedge clk) begin
    #3;
    if (valid_a) nv_a++;
    if (valid_b) nv_b++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_a();
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
  endtask

  task automatic pulse_b();
    @(negedge clk); start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
  endtask

  // Returns number of negedges until meas_valid is seen, or -1 on timeout.
  task automatic wait_valid_a(input int budget, output int c);
    c = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (valid_a) begin c = i; break; end
    end
  endtask

  task automatic wait_valid_b(input int budget, output int c);
    c = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (valid_b) begin c = i; break; end
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    chk("rst_busy",   busy_a,    0);
    chk("rst_valid",  valid_a,   0);
    chk("rst_period", per_tot_a, 0);
    chk("rst_high",   hi_tot_a,  0);
    chk("rst_ovf",    ovf_a,     0);

    // Normal measurement: 20-clk period, 14 high, 10 periods -> 200/140
    en_a = 1;
    repeat (40) @(negedge clk);
    pulse_a();
    chk("norm_busy_up", busy_a, 1);
    wait_valid_a(600, cyc);
    chk("norm_seen",   (cyc > 0), 1);
    chk("norm_period", per_tot_a, 200);
    chk("norm_high",   hi_tot_a,  140);
    chk("norm_ovf",    ovf_a,     0);
`ifndef THEE_PERIOD_METER_CONT_EN
    chk("norm_busy_dn", busy_a, 0);
    nv0 = nv_a;
    repeat (50) @(negedge clk);
    chk("norm_hold_period", per_tot_a, 200);
    chk("norm_no_repeat", nv_a - nv0, 0);
`else
    do_reset();
`endif

    // Start coincident with a rise (rise reaches FSM 2 clk after ph_a==0 edge),
    // plus a second start during MEASURE that must be ignored.
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ph_a == 2) break;
    end
    start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    chk("edge_busy_up", busy_a, 1);
    nv0 = nv_a;
    repeat (98) @(negedge clk);
    pulse_a();
    // Opening rise 20 clk after start, closing 200 later: valid 221 negedges after
    // the start negedge, 101 already elapsed.
    wait_valid_a(400, cyc);
    chk("edge_latency", cyc, 120);
    chk("edge_period",  per_tot_a, 200);
    chk("edge_high",    hi_tot_a,  140);
`ifndef THEE_PERIOD_METER_CONT_EN
    repeat (300) @(negedge clk);
    chk("edge_one_result", nv_a - nv0, 1);
    chk("edge_idle", busy_a, 0);
`else
    do_reset();
`endif

    // Reset after ~5 input edges into MEASURE
    pulse_a();
    repeat (130) @(negedge clk);
    chk("mid_busy_before", busy_a, 1);
    nv0 = nv_a;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy",   busy_a,    0);
    chk("mid_rst_valid",  valid_a,   0);
    chk("mid_rst_period", per_tot_a, 0);
    chk("mid_rst_high",   hi_tot_a,  0);
    chk("mid_rst_ovf",    ovf_a,     0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    chk("mid_no_valid", nv_a - nv0, 0);
    chk("mid_idle", busy_a, 0);
    pulse_a();
    wait_valid_a(600, cyc);
    chk("mid_seen",   (cyc > 0), 1);
    chk("mid_period", per_tot_a, 200);
    chk("mid_high",   hi_tot_a,  140);
    chk("mid_ovf",    ovf_a,     0);

    // Overflow: CNT_W=8, period 30 -> window of 300 saturates
    en_b = 1;
    repeat (40) @(negedge clk);
    pulse_b();
    wait_valid_b(1000, cyc);
    chk("ovf_seen",   (cyc > 0), 1);
    chk("ovf_flag",   ovf_b,     1);
    chk("ovf_period", per_tot_b, 255);
    chk("ovf_high",   hi_tot_b,  255);
    chk("ovf_busy",   busy_b,    0);

    // Stuck-low input: ARM times out 256 cycles after start is accepted
    en_b = 0;
    repeat (10) @(negedge clk);
    pulse_b();
    wait_valid_b(400, cyc);
    chk("stuck_latency", cyc, 256);
    chk("stuck_flag",    ovf_b,     1);
    chk("stuck_period",  per_tot_b, 255);
    chk("stuck_busy",    busy_b,    0);

`ifdef THEE_PERIOD_METER_CONT_EN
    // Continuous mode: a result every 200 clk, busy held high
    do_reset();
    pulse_a();
    wait_valid_a(600, cyc);
    chk("cont_first_seen", (cyc > 0), 1);
    chk("cont_first_period", per_tot_a, 200);
    chk("cont_first_high",   hi_tot_a,  140);
    for (int k = 0; k < 2; k++) begin
      wait_valid_a(300, cyc);
      chk("cont_interval", cyc, 200);
      chk("cont_period", per_tot_a, 200);
      chk("cont_high",   hi_tot_a,  140);
      chk("cont_ovf",    ovf_a,     0);
      chk("cont_busy",   busy_a,    1);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/thee_pulse_period_meter.md
# thee_pulse_period_meter

Synthesizable period and duty-cycle meter that sits directly downstream of an oscillator output such as the 555 astable model's `clk`. It samples the asynchronous oscillator output in a reference clock domain. It accumulates reference-clock ticks over a fixed number of input periods and reports total period ticks and total high ticks. It is the gate-level counterpart to the behavioural real-valued frequency meter, for designs where the measurement must exist in silicon.

## Interface
Parameters:
- `CNT_W`, 24, width of both accumulators and result ports.
- `MEAS_WINDOW`, 10, number of input periods per measurement; must be ≥1.
- `SYNC_STAGES`, 2, synchronizer flops on `sig_in`; must be ≥2.

Ports:
- `clk`  input  1  reference clock; all logic on its rising edge.
- `rst_n`  input  1  asynchronous active-low reset.
- `sig_in`  input  1  asynchronous oscillator output under measurement.
- `start`  input  1  single-cycle request to begin a measurement; ignored unless IDLE.
- `busy`  output  1  high in ARM and MEASURE.
- `meas_valid`  output  1  single-cycle pulse when the result ports update.
- `period_total`  output  CNT_W  reference ticks spanning MEAS_WINDOW input periods.
- `high_total`  output  CNT_W  reference ticks with the synchronized input high within that span.
- `overflow`  output  1  qualifies the current result; 1 means the accumulator saturated and the result is invalid.

## Operation
- `sig_in` passes through the SYNC_STAGES flop chain to give `sig_s`, plus one delay flop `sig_d`. `rise = sig_s & ~sig_d`.
- FSM states: IDLE, ARM, MEASURE.
  - IDLE: on `start`, clear the accumulators and the edge counter, then go to ARM.
  - ARM: the period accumulator counts as a timeout. On `rise`, clear the accumulators, set the edge count to 0, and go to MEASURE.
  - MEASURE, every cycle:
    - `period_acc += 1`.
    - `high_acc += sig_s`.
    - On `rise`, increment the edge count.
    - When `rise` occurs and the edge count reaches MEAS_WINDOW, the closing edge has arrived.
  - On the closing edge:
    - Latch `period_total`/`high_total`.
    - Set `overflow=0` and pulse `meas_valid`.
    - Go to IDLE, or see Configuration.
- Counting window: from the opening `rise` cycle inclusive to the closing `rise` cycle exclusive. An ideal input of period P ticks gives exactly MEAS_WINDOW·P.
- Saturation, in ARM or MEASURE:
  - If `period_acc` would exceed 2^CNT_W−1, abort.
  - Latch `period_total`, `high_total` = all ones.
  - Set `overflow=1`, pulse `meas_valid`, and go to IDLE.
  - This covers a stuck input and windows that are too long.
- `start` while busy is ignored. A `rise` coincident with the `start` cycle is not used as the opening edge.

## Timing
- Reset values: `busy=0`, `meas_valid=0`, `period_total=0`, `high_total=0`, `overflow=0`, FSM=IDLE, all synchronizer flops 0.
- `sig_in` transition to `rise`: SYNC_STAGES+1 clk cycles.
- `meas_valid` and the result ports are registered. They update on the clk edge after the closing-`rise` cycle.
- Results hold until the next `meas_valid`.
- `busy` rises the cycle after `start` is accepted and falls in the same cycle that `meas_valid` asserts, unless continuous mode is enabled.
- `rst_n` asserted mid-measurement:
  - All state clears immediately with no `meas_valid`.
  - After release, the block waits in IDLE for `start`.

## Configuration
- `THEE_PERIOD_METER_CONT_EN` defined: after a normal completion the FSM stays in MEASURE.
  - The closing edge becomes the opening edge of the next window, so no input period is lost.
  - The accumulators restart from 1 and `high_acc` restarts from `sig_s` in that cycle.
  - `busy` stays high. `meas_valid` pulses once per window.
  - An overflow abort still returns to IDLE.
- Undefined: every completion returns to IDLE and a new `start` is required.

## Test plan
- Normal measurement: `sig_in` period 20 clk, high 14 clk, MEAS_WINDOW=10, `start` pulse → one `meas_valid`, `period_total=200`, `high_total=140`, `overflow=0`, `busy` low afterwards.
- Overflow: CNT_W=8, `sig_in` period 30 clk, MEAS_WINDOW=10 → `meas_valid` with `overflow=1`, `period_total=255`, `high_total=255`.
- Stuck input: `sig_in` held 0, CNT_W=8, `start` → abort from ARM after 256 cycles with `overflow=1`, `busy=0`.
- Reset mid-measurement: assert `rst_n=0` after 5 input edges → all outputs 0 immediately, no `meas_valid`. A later `start` gives a correct 200/140 result.
- Busy and edge handling: a `start` pulse during MEASURE is ignored, and exactly one result is produced. A `rise` in the `start` cycle is not the opening edge, so the result is still 200.
- Continuous mode (`THEE_PERIOD_METER_CONT_EN`): a 20-clk input produces `meas_valid` every 200 clk, each with 200/140, and `busy` stays high throughout.
